// File: rtl/data_mem_hs.sv
// data_mem_hs: byte-addressable little-endian data memory with a
// valid/ready request port and a registered one-cycle response pulse.
// Every request passes through IDLE -> WAIT (x WAIT) -> COMMIT -> RESP.
// Requests are strictly serialised, so a load always sees earlier stores.
// Optional feature macro: DMEM_ALIGN_CHECK_EN. When it is defined,
// misaligned half/word accesses are rejected with rsp_fault.
// The byte array is never cleared by rst.
module data_mem_hs #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault,
    output logic              busy
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Load extension: sign or zero extension of a byte or half to the full word.
    function automatic logic [DATA_W-1:0] load_extend(
        input logic [DATA_W-1:0] raw,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [DATA_W-1:0] ext;
        case (size)
            2'b00:   ext = {{24{~uns & raw[7]}}, raw[7:0]};
            2'b01:   ext = {{16{~uns & raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
        return ext;
    endfunction

    // Byte enables for an access size. Size 11 behaves as a word.
    function automatic logic [3:0] size_enables(input logic [1:0] size);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001;
            2'b01:   be = 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    state_t            state_r, state_s;
    logic [3:0]        cnt_r, cnt_s;
    logic              req_ready_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              busy_r;

    // Request fields captured at accept time.
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [1:0]        size_r;
    logic              uns_r;
    logic [DATA_W-1:0] wdata_r;

    logic              accept_s;
    logic              commit_s;
    logic              misaligned_s;
    logic              wr_en_s;
    logic [3:0]        be_s;
    logic [ADDR_W-1:0] byte_addr_s [0:3];
    logic [DATA_W-1:0] rd_raw_s;
    logic [DATA_W-1:0] load_s;

    logic [7:0]        mem [0:(2**ADDR_W)-1];

    assign accept_s = req_valid && req_ready_r;
    assign commit_s = (state_r == ST_COMMIT);

`ifdef DMEM_ALIGN_CHECK_EN
    logic rsp_fault_r;

    // A half must sit on an even address and a word on a multiple of four.
    always_comb begin
        misaligned_s = 1'b0;
        if ((size_r == 2'b01) && addr_r[0]) begin
            misaligned_s = 1'b1;
        end else if (size_r[1] && (addr_r[1:0] != 2'b00)) begin
            misaligned_s = 1'b1;
        end else begin
            misaligned_s = 1'b0;
        end
    end

    // The fault flag is updated only in COMMIT, so it holds until the next response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_fault_r <= 1'b0;
        end else if (commit_s) begin
            rsp_fault_r <= misaligned_s;
        end else begin
            rsp_fault_r <= rsp_fault_r;
        end
    end

    assign rsp_fault = rsp_fault_r;
`else
    // Without the check, misaligned accesses are performed byte-wise with wrap-around.
    assign misaligned_s = 1'b0;
    assign rsp_fault    = 1'b0;
`endif

    // Per-byte addresses. Arithmetic wraps naturally at the ADDR_W boundary.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            byte_addr_s[k] = addr_r + ADDR_W'(k);
        end
    end

    // Store path: byte enables and the write strobe. rst suppresses a write on the COMMIT edge.
    always_comb begin
        be_s    = size_enables(size_r);
        wr_en_s = 1'b0;
        if (commit_s && we_r && !misaligned_s && !rst) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Load path: gather four bytes little-endian, then extend by size and signedness.
    always_comb begin
        rd_raw_s = {mem[byte_addr_s[3]], mem[byte_addr_s[2]],
                    mem[byte_addr_s[1]], mem[byte_addr_s[0]]};
        load_s   = load_extend(rd_raw_s, size_r, uns_r);
    end

    // Byte array write port. No reset, so contents survive rst.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_en_s && be_s[k]) begin
                mem[byte_addr_s[k]] <= wdata_r[8*k +: 8];
            end
        end
    end

    // Next-state and wait counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_s   = WAIT_CNT;
                    state_s = (WAIT_CNT == 4'd0) ? ST_COMMIT : ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    cnt_s   = 4'd0;
                    state_s = ST_COMMIT;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                    state_s = ST_WAIT;
                end
            end
            ST_COMMIT: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                cnt_s   = 4'd0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            req_ready_r <= (state_s == ST_IDLE);
            busy_r      <= (state_s != ST_IDLE);
            rsp_valid_r <= commit_s;
            if (commit_s) begin
                rsp_rdata_r <= (we_r || misaligned_s) ? '0 : load_s;
            end else begin
                rsp_rdata_r <= rsp_rdata_r;
            end
        end
    end

    // Capture request fields on accept. rst discards any captured request.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r    <= 1'b0;
            addr_r  <= '0;
            size_r  <= 2'b00;
            uns_r   <= 1'b0;
            wdata_r <= '0;
        end else if (accept_s) begin
            we_r    <= req_we;
            addr_r  <= req_addr;
            size_r  <= req_size;
            uns_r   <= req_unsigned;
            wdata_r <= req_wdata;
        end else begin
            we_r    <= we_r;
            addr_r  <= addr_r;
            size_r  <= size_r;
            uns_r   <= uns_r;
            wdata_r <= wdata_r;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_data_mem_hs.sv
// Testbench for data_mem_hs. A scoreboard queue is filled at issue time
// from a byte-array reference model. A separate monitor pops and compares
// each response pulse. Directed cases are followed by randomized traffic.
module tb_data_mem_hs;

    localparam int ADDR_W = 16;
    localparam int WAIT_P = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    rsp_t        sb[$];
    logic [7:0]  ref_mem [0:65535];
    logic [31:0] last_rdata = 32'h0;
    logic        last_fault = 1'b0;

    data_mem_hs #(.DATA_W(32), .ADDR_W(ADDR_W), .WAIT(WAIT_P)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_misaligned(input logic [15:0] addr, input logic [1:0] size);
`ifdef DMEM_ALIGN_CHECK_EN
        return ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    // Reference load: little-endian gather, then numeric sign or zero extension.
    function automatic logic [31:0] model_load(input logic [15:0] addr, input logic [1:0] size, input logic uns);
        int n;
        logic [31:0] v;
        n = nbytes(size);
        v = 32'h0;
        for (int k = 0; k < n; k++) begin
            v = v | (32'(ref_mem[16'(addr + 16'(k))]) << (8 * k));
        end
        if (!uns && n < 4 && v[8*n-1]) begin
            v = v | ~((32'h1 << (8 * n)) - 32'h1);
        end
        return v;
    endfunction

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            check("rsp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // mode 0: wait for response; 1: expect response but return right after accept;
    // 2: no response expected (request will be reset away)
    task automatic issue(input logic we, input logic [15:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata, input int mode);
        int   n;
        rsp_t e;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        if (mode != 2) begin
            if (is_misaligned(addr, size)) begin
                e.rdata = 32'h0;
                e.fault = 1'b1;
            end else if (we) begin
                for (int k = 0; k < nbytes(size); k++) begin
                    ref_mem[16'(addr + 16'(k))] = wdata[8*k +: 8];
                end
                e.rdata = 32'h0;
                e.fault = 1'b0;
            end else begin
                e.rdata = model_load(addr, size, uns);
                e.fault = 1'b0;
            end
            sb.push_back(e);
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        if (mode == 0) begin
            wait_done();
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                last_rdata = rsp_rdata;
                last_fault = rsp_fault;
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_fault", 32'(rsp_fault), 32'(e.fault));
                end
            end
        end
    end

    initial begin
        logic [15:0] a;
        logic [1:0]  sz;
        for (int i = 0; i < 65536; i++) begin
            ref_mem[i] = 8'h00;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_fault", 32'(rsp_fault), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // Fill two regions (including the wrap-around edge) with known data
        for (int i = 0; i < 256; i += 4) begin
            issue(1'b1, 16'(i), 2'b10, 1'b0, $urandom, 0);
            issue(1'b1, 16'(16'hFF00 + 16'(i)), 2'b10, 1'b0, $urandom, 0);
        end

        // Test 1: store word, then load with every extension form
        issue(1'b1, 16'h0100, 2'b10, 1'b0, 32'hDEADBEEF, 0);
        check("sw_rdata_zero", last_rdata, 32'h0);
        issue(1'b0, 16'h0103, 2'b00, 1'b0, 32'h0, 0);
        check("lb_0103", last_rdata, 32'hFFFFFFDE);
        issue(1'b0, 16'h0103, 2'b00, 1'b1, 32'h0, 0);
        check("lbu_0103", last_rdata, 32'h000000DE);
        issue(1'b0, 16'h0102, 2'b01, 1'b0, 32'h0, 0);
        check("lh_0102", last_rdata, 32'hFFFFDEAD);
        issue(1'b0, 16'h0100, 2'b01, 1'b1, 32'h0, 0);
        check("lhu_0100", last_rdata, 32'h0000BEEF);
        issue(1'b0, 16'h0100, 2'b10, 1'b0, 32'h0, 0);
        check("lw_0100", last_rdata, 32'hDEADBEEF);

        // Test 2: handshake timing around one request
        issue(1'b0, 16'h0100, 2'b11, 1'b0, 32'h0, 1);
        for (int c = 1; c <= WAIT_P + 3; c++) begin
            @(negedge clk);
            check($sformatf("lat_ready_c%0d", c), 32'(req_ready), (c == WAIT_P + 3) ? 32'd1 : 32'd0);
            check($sformatf("lat_valid_c%0d", c), 32'(rsp_valid), (c == WAIT_P + 2) ? 32'd1 : 32'd0);
            check($sformatf("lat_busy_c%0d", c), 32'(busy), (c <= WAIT_P + 2) ? 32'd1 : 32'd0);
        end
        wait_done();
        check("lw_size3", last_rdata, 32'hDEADBEEF);

        // Test 3: misaligned word store
        issue(1'b1, 16'h0101, 2'b10, 1'b0, 32'h11223344, 0);
`ifdef DMEM_ALIGN_CHECK_EN
        check("mis_fault", 32'(last_fault), 32'd1);
        issue(1'b0, 16'h0100, 2'b10, 1'b0, 32'h0, 0);
        check("mis_prior", last_rdata, 32'hDEADBEEF);
`else
        check("mis_nofault", 32'(last_fault), 32'd0);
        issue(1'b0, 16'h0101, 2'b10, 1'b0, 32'h0, 0);
        check("lw_0101", last_rdata, 32'h11223344);

        // Test 4: address wrap-around
        issue(1'b1, 16'hFFFE, 2'b10, 1'b0, 32'hAABBCCDD, 0);
        issue(1'b0, 16'hFFFE, 2'b00, 1'b1, 32'h0, 0);
        check("wrap_fffe", last_rdata, 32'h000000DD);
        issue(1'b0, 16'hFFFF, 2'b00, 1'b1, 32'h0, 0);
        check("wrap_ffff", last_rdata, 32'h000000CC);
        issue(1'b0, 16'h0000, 2'b00, 1'b1, 32'h0, 0);
        check("wrap_0000", last_rdata, 32'h000000BB);
        issue(1'b0, 16'h0001, 2'b00, 1'b1, 32'h0, 0);
        check("wrap_0001", last_rdata, 32'h000000AA);
`endif

        // Test 5: reset while in WAIT discards the store
        issue(1'b1, 16'h0200, 2'b10, 1'b0, 32'h0, 0);
        issue(1'b1, 16'h0200, 2'b10, 1'b0, 32'h55AA55AA, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready_lo", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("midrst_ready_hi", 32'(req_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (WAIT_P + 4) @(negedge clk);
        issue(1'b0, 16'h0200, 2'b10, 1'b0, 32'h0, 0);
        check("midrst_lw", last_rdata, 32'h00000000);

        // Randomized traffic over the initialised regions
        for (int i = 0; i < 200; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 252))
                                              : 16'(16'hFF00 + 16'($urandom_range(0, 255)));
            issue(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom, 0);
        end

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
